multi_clock_tick_scheduler: RTL and testbench

Single-clock scheduler that produces six independent, programmable-period tick strobes. Each strobe is a one-cycle enable that drives one counter channel of the multi-clock counter datapath. It replaces six free-running clocks with clock enables in one domain, and each channel's period and start phase are configured over a valid/ready port. A small run-control FSM sequences configuration, phase alignment and free-running operation.

---
 rtl/multi_clock_tick_scheduler.sv | 109 ++++++++++
 tb/tb_multi_clock_tick_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_tick_scheduler.sv
// Six-channel (NCH) tick-strobe generator: per-channel programmable period and
// start phase, sequenced by an IDLE/SYNC/RUN run-control FSM in a single clock domain.

module tick_lane #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             load,
  input  logic             run,
  output logic             tick
);
  logic             en;
  logic [DIV_W-1:0] div, phase, cnt, start_cnt;

  // Out-of-range phase is kept as written; only the loaded count is clamped.
  assign start_cnt = (phase > div) ? div : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b0;
      div   <= '0;
      phase <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
    end else begin
      if (wr) begin
        en    <= wr_en;
        div   <= wr_div;
        phase <= wr_phase;
      end
      tick <= run & en & (cnt == '0);
      if (load)
        cnt <= start_cnt;
      else if (run && en)
        cnt <= (cnt == '0) ? div : cnt - 1'b1;
    end
  end
endmodule

module multi_clock_tick_scheduler #(
  parameter int NCH   = 6,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             start,
  input  logic             stop,
  output logic             running,
  output logic [NCH-1:0]   tick,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  state_t state, state_nxt;

  logic cfg_acc, ch_bad, load, run;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop beats start in IDLE; SYNC always proceeds to RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = SYNC;
      SYNC:    state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_ready = (state == IDLE);
  assign running   = (state == RUN);
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign ch_bad    = ({1'b0, cfg_ch} >= 4'(NCH));
  assign load      = (state == SYNC);
  assign run       = (state == RUN) & ~stop;

  always_ff @(posedge clk) begin
    if (rst)                  cfg_err <= 1'b0;
    else if (cfg_acc && ch_bad) cfg_err <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    tick_lane #(.DIV_W(DIV_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr       (cfg_acc && (cfg_ch == 3'(i))),
      .wr_en    (cfg_en),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .load     (load),
      .run      (run),
      .tick     (tick[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_tick_scheduler.sv
// Directed bench for multi_clock_tick_scheduler; expected tick patterns come from
// the configured period/phase per channel.

module tb_multi_clock_tick_scheduler;
  localparam int NCH   = 6;
  localparam int DIV_W = 8;

  logic             clk, rst, cfg_valid, cfg_ready, cfg_en, start, stop, running, cfg_err;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div, cfg_phase;
  logic [NCH-1:0]   tick;

  int nvec = 0;
  int nerr = 0;
  int m_en  [NCH];
  int m_div [NCH];
  int m_ph  [NCH];

  multi_clock_tick_scheduler #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .start(start), .stop(stop), .running(running), .tick(tick), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected strobes m cycles after edge E2 of a start.
  function automatic logic [NCH-1:0] exp_tick(int m);
    logic [NCH-1:0] r;
    int c;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      c = (m_ph[i] > m_div[i]) ? m_div[i] : m_ph[i];
      r[i] = (m_en[i] != 0) && (m >= c) && (((m - c) % (m_div[i] + 1)) == 0);
    end
    return r;
  endfunction

  task automatic cfg_write(input int ch, input int en, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_en    = en[0];
    cfg_div   = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    cyc();
    cfg_valid = 1'b0;
    if (ch < NCH) begin
      m_en[ch] = en; m_div[ch] = dv; m_ph[ch] = ph;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    nvec++; if (tick !== '0)       begin nerr++; $display("FAIL reset_tick: got %b want 0", tick); end
    nvec++; if (running !== 1'b0)  begin nerr++; $display("FAIL reset_running: got %b want 0", running); end
    nvec++; if (cfg_err !== 1'b0)  begin nerr++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_two_channel();
    logic [NCH-1:0] e;
    cfg_write(0, 1, 0, 0);
    cfg_write(1, 1, 3, 2);
    do_start();
    nvec++; if (running !== 1'b1) begin nerr++; $display("FAIL two_running: got %b want 1", running); end
    nvec++; if (tick !== '0) begin nerr++; $display("FAIL two_tick_e1: got %b want 0", tick); end
    for (int m = 0; m < 12; m++) begin
      cyc();
      // ch0 every cycle; ch1 at E4, E8, E12
      e = 6'b000001 | (((m == 2) || (m == 6) || (m == 10)) ? 6'b000010 : 6'b000000);
      nvec++; if (tick !== e) begin nerr++; $display("FAIL two_tick m=%0d: got %b want %b", m, tick, e); end
    end
    do_stop();
  endtask

  task automatic test_cfg_blocked();
    do_start();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_en = 1'b1; cfg_div = 8'd5; cfg_phase = 8'd0;
    for (int m = 0; m < 6; m++) begin
      cyc();
      nvec++; if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL blk_ready m=%0d: got %b want 0", m, cfg_ready); end
      nvec++; if (tick !== exp_tick(m)) begin nerr++; $display("FAIL blk_tick m=%0d: got %b want %b", m, tick, exp_tick(m)); end
    end
    do_stop();
    nvec++; if (tick !== '0) begin nerr++; $display("FAIL blk_stop_tick: got %b want 0", tick); end
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL blk_stop_running: got %b want 0", running); end
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL blk_stop_ready: got %b want 1", cfg_ready); end
    cyc();
    cfg_valid = 1'b0;
    m_div[0] = 5;
    do_start();
    for (int m = 0; m < 14; m++) begin
      cyc();
      nvec++; if (tick !== exp_tick(m)) begin nerr++; $display("FAIL blk_p6 m=%0d: got %b want %b", m, tick, exp_tick(m)); end
    end
    do_stop();
  endtask

  task automatic test_invalid_clamp();
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL inv_err_before: got %b want 0", cfg_err); end
    cfg_write(7, 1, 0, 0);
    nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL inv_err_after: got %b want 1", cfg_err); end
    cfg_write(2, 1, 1, 9);
    do_start();
    for (int m = 0; m < 8; m++) begin
      cyc();
      nvec++; if (tick[2] !== ((m % 2) == 1)) begin nerr++; $display("FAIL clamp_ch2 m=%0d: got %b want %b", m, tick[2], (m % 2) == 1); end
      nvec++; if (tick !== exp_tick(m)) begin nerr++; $display("FAIL inv_tick m=%0d: got %b want %b", m, tick, exp_tick(m)); end
    end
    do_stop();
    nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL inv_err_sticky: got %b want 1", cfg_err); end
  endtask

  task automatic test_collision_restart();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL col_ready: got %b want 1", cfg_ready); end
    cyc();
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL col_running: got %b want 0", running); end
    // stop during SYNC is ignored
    start = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    nvec++; if (running !== 1'b1) begin nerr++; $display("FAIL sync_stop_running: got %b want 1", running); end
    for (int m = 0; m < 5; m++) begin
      start = (m == 2);
      cyc();
      nvec++; if (tick !== exp_tick(m)) begin nerr++; $display("FAIL col_tick m=%0d: got %b want %b", m, tick, exp_tick(m)); end
    end
    start = 1'b0;
    do_stop();
    nvec++; if (tick !== '0) begin nerr++; $display("FAIL col_stop_tick: got %b want 0", tick); end
    do_start();
    for (int m = 0; m < 10; m++) begin
      cyc();
      nvec++; if (tick !== exp_tick(m)) begin nerr++; $display("FAIL restart_tick m=%0d: got %b want %b", m, tick, exp_tick(m)); end
    end
  endtask

  task automatic test_reset_mid();
    // still running from the previous scenario
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nvec++; if (tick !== '0) begin nerr++; $display("FAIL rmid_tick: got %b want 0", tick); end
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL rmid_running: got %b want 0", running); end
    nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL rmid_cfg_err: got %b want 0", cfg_err); end
    for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_div[i] = 0; m_ph[i] = 0; end
    do_start();
    nvec++; if (running !== 1'b1) begin nerr++; $display("FAIL rmid_restart_running: got %b want 1", running); end
    for (int m = 0; m < 10; m++) begin
      cyc();
      nvec++; if (tick !== '0) begin nerr++; $display("FAIL rmid_notick m=%0d: got %b want 0", m, tick); end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
    cfg_div = '0; cfg_phase = '0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_div[i] = 0; m_ph[i] = 0; end
    test_reset();
    test_two_channel();
    test_cfg_blocked();
    test_invalid_clamp();
    test_collision_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
